// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: scheduler states and
// default build constants.
package fir_pkg;

    localparam int unsigned FIR_NBADD    = 8;
    localparam int unsigned FIR_FILT_ORD = 96;
    localparam int unsigned FIR_RD_LAT   = 2;
    localparam int unsigned FIR_NBOUTA   = 12;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        ISSUE,
        DRAIN,
        STORE
    } fir_state_t;

endpackage

// File: rtl/lat_pipe.sv
// Fixed-depth 1-bit delay line; aligns the MAC enable with memory read latency.
// Ports: clk, rst (async, active-high), d (input bit), q (d delayed DEPTH clocks).
module lat_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;

    // Shift toward the MSB; the cast drops the bit that falls off the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= DEPTH'({sr_q, d});
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fir_sched.sv
// FIR sequencing controller: captures a sample strobe, writes the input buffer,
// issues one coefficient/data address pair per clock, delays the MAC enable by
// the memory read latency and commits the result to the output buffer.
// Ports: clk, rst (async, active-high), sample_stb (new sample pulse);
//   in_wr/in_addr (input buffer), coef_addr (coefficient memory),
//   acc_clr/mac_en (accumulator control), out_wr/out_addr (output buffer),
//   done (commit pulse), busy (not IDLE), overrun (sticky sample drop).
module fir_sched
    import fir_pkg::*;
#(
    parameter int unsigned NBADD    = FIR_NBADD,
    parameter int unsigned FILT_ORD = FIR_FILT_ORD,
    parameter int unsigned RD_LAT   = FIR_RD_LAT,
    parameter int unsigned NBOUTA   = FIR_NBOUTA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_stb,
    output logic              in_wr,
    output logic [NBADD-1:0]  in_addr,
    output logic [NBADD-1:0]  coef_addr,
    output logic              acc_clr,
    output logic              mac_en,
    output logic              out_wr,
    output logic [NBOUTA-1:0] out_addr,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned DW = 3;  // drain counter width, covers RD_LAT up to 4

    fir_state_t        state_q, state_d;
    logic [NBADD-1:0]  j_q, j_d;
    logic [NBADD-1:0]  idx_q, idx_d;
    logic [NBADD-1:0]  wp_q, wp_d;
    logic [NBOUTA-1:0] kk_q, kk_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;

    logic              in_wr_q, in_wr_d;
    logic [NBADD-1:0]  in_addr_q, in_addr_d;
    logic [NBADD-1:0]  coef_addr_q, coef_addr_d;
    logic              acc_clr_q, acc_clr_d;
    logic              out_wr_q, out_wr_d;
    logic [NBOUTA-1:0] out_addr_q, out_addr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              issue_v_q, issue_v_d;

    // State, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            j_q         <= '0;
            idx_q       <= '0;
            wp_q        <= '0;
            kk_q        <= '0;
            dcnt_q      <= '0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            in_wr_q     <= 1'b0;
            in_addr_q   <= '0;
            coef_addr_q <= '0;
            acc_clr_q   <= 1'b0;
            out_wr_q    <= 1'b0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            issue_v_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            idx_q       <= idx_d;
            wp_q        <= wp_d;
            kk_q        <= kk_d;
            dcnt_q      <= dcnt_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            in_wr_q     <= in_wr_d;
            in_addr_q   <= in_addr_d;
            coef_addr_q <= coef_addr_d;
            acc_clr_q   <= acc_clr_d;
            out_wr_q    <= out_wr_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            issue_v_q   <= issue_v_d;
        end
    end

    // Next state; outputs are decoded from the state being entered so they
    // are valid registered values during that state's cycle.
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        idx_d       = idx_q;
        wp_d        = wp_q;
        kk_d        = kk_q;
        dcnt_d      = dcnt_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        in_wr_d     = 1'b0;
        in_addr_d   = '0;
        coef_addr_d = '0;
        acc_clr_d   = 1'b0;
        out_wr_d    = 1'b0;
        out_addr_d  = '0;
        done_d      = 1'b0;
        issue_v_d   = 1'b0;

        // One-deep queue; a strobe arriving with the queue full is dropped.
        if (sample_stb && (state_q != IDLE)) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sample_stb || pend_q) begin
                    state_d = WRITE;
                    pend_d  = 1'b0;
                end
            end
            WRITE: begin
                state_d = ISSUE;
                j_d     = '0;
                idx_d   = wp_q;
            end
            ISSUE: begin
                if (j_q == NBADD'(FILT_ORD - 1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    j_d   = j_q + NBADD'(1);
                    idx_d = (idx_q == '0) ? NBADD'(FILT_ORD - 1) : idx_q - NBADD'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DW'(RD_LAT - 1)) state_d = STORE;
                else                           dcnt_d  = dcnt_q + DW'(1);
            end
            STORE: begin
                kk_d = kk_q + NBOUTA'(1);
                wp_d = (wp_q == NBADD'(FILT_ORD - 1)) ? '0 : wp_q + NBADD'(1);
                if (pend_d) begin
                    state_d = WRITE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            WRITE: begin
                in_wr_d   = 1'b1;
                in_addr_d = wp_d;
                acc_clr_d = 1'b1;
            end
            ISSUE: begin
                coef_addr_d = j_d;
                in_addr_d   = idx_d;
                issue_v_d   = 1'b1;
            end
            STORE: begin
                out_wr_d   = 1'b1;
                out_addr_d = kk_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
        .clk (clk),
        .rst (rst),
        .d   (issue_v_q),
        .q   (mac_en)
    );

    assign in_wr     = in_wr_q;
    assign in_addr   = in_addr_q;
    assign coef_addr = coef_addr_q;
    assign acc_clr   = acc_clr_q;
    assign out_wr    = out_wr_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched: default build plus a small FILT_ORD=4,
// RD_LAT=4, NBOUTA=3 build for latency and pointer-wrap corners.
module tb_fir_sched;

    localparam int FO  = 96;
    localparam int RL  = 2;
    localparam int FO2 = 4;
    localparam int RL2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_stb = 1'b0;
    logic sample_stb2 = 1'b0;

    logic        in_wr, acc_clr, mac_en, out_wr, done, busy, overrun;
    logic [7:0]  in_addr, coef_addr;
    logic [11:0] out_addr;

    logic        in_wr2, acc_clr2, mac_en2, out_wr2, done2, busy2, overrun2;
    logic [1:0]  in_addr2, coef_addr2;
    logic [2:0]  out_addr2;

    int checks = 0;
    int errors = 0;
    int mac_cnt = 0;
    int done_cnt = 0;
    int mac2_cnt = 0;
    int exp_wp = 0;
    int exp_kk = 0;

    always #5 clk = ~clk;

    fir_sched dut (
        .clk(clk), .rst(rst), .sample_stb(sample_stb),
        .in_wr(in_wr), .in_addr(in_addr), .coef_addr(coef_addr),
        .acc_clr(acc_clr), .mac_en(mac_en), .out_wr(out_wr),
        .out_addr(out_addr), .done(done), .busy(busy), .overrun(overrun)
    );

    fir_sched #(.NBADD(2), .FILT_ORD(FO2), .RD_LAT(RL2), .NBOUTA(3)) dut2 (
        .clk(clk), .rst(rst), .sample_stb(sample_stb2),
        .in_wr(in_wr2), .in_addr(in_addr2), .coef_addr(coef_addr2),
        .acc_clr(acc_clr2), .mac_en(mac_en2), .out_wr(out_wr2),
        .out_addr(out_addr2), .done(done2), .busy(busy2), .overrun(overrun2)
    );

    always @(negedge clk) begin
        if (mac_en)  mac_cnt  <= mac_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
        if (mac_en2) mac2_cnt <= mac2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    // Entered in the WRITE cycle; leaves in the STORE cycle. Optional strobes
    // are injected during ISSUE index inj_a / inj_b.
    task automatic run_full(input int inj_a, input int inj_b);
        int base;
        check("wr_in_wr",   32'(in_wr), 32'd1);
        check("wr_acc_clr", 32'(acc_clr), 32'd1);
        check("wr_in_addr", 32'(in_addr), 32'(exp_wp));
        check("wr_busy",    32'(busy), 32'd1);
        base = mac_cnt;
        for (int j = 0; j < FO; j++) begin
            tick();
            check("iss_coef",   32'(coef_addr), 32'(j));
            check("iss_in",     32'(in_addr), 32'((exp_wp + FO - j) % FO));
            check("iss_mac",    32'(mac_en), 32'(j >= RL));
            check("iss_in_wr",  32'(in_wr), 32'd0);
            sample_stb = (j == inj_a) || (j == inj_b);
        end
        sample_stb = 1'b0;
        for (int d = 0; d < RL; d++) begin
            tick();
            check("drn_mac",  32'(mac_en), 32'd1);
            check("drn_owr",  32'(out_wr), 32'd0);
        end
        tick();
        check("st_out_wr", 32'(out_wr), 32'd1);
        check("st_done",   32'(done), 32'd1);
        check("st_oaddr",  32'(out_addr), 32'(exp_kk));
        check("st_mac",    32'(mac_en), 32'd0);
        check("st_maccnt", 32'(mac_cnt - base), 32'(FO));
        exp_kk = (exp_kk + 1) % 4096;
        exp_wp = (exp_wp + 1) % FO;
    endtask

    initial begin
        int d0;
        int lat;
        repeat (3) tick();
        check("rst_ctl", {25'd0, in_wr, acc_clr, mac_en, out_wr, done, busy, overrun}, 32'd0);
        check("rst_adr", {in_addr, coef_addr, out_addr}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Single sample plus enough spaced samples to wrap the write pointer.
        for (int n = 0; n < FO + 1; n++) begin
            pulse();
            run_full(-1, -1);
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            tick();
        end
        check("ovr_none", 32'(overrun), 32'd0);

        // Queued second sample: WRITE directly after STORE, no overrun.
        d0 = done_cnt;
        pulse();
        run_full(38, -1);
        tick();
        check("q_ovr0", 32'(overrun), 32'd0);
        run_full(-1, -1);
        tick();
        check("q_idle", 32'(busy), 32'd0);
        check("q_dones", 32'(done_cnt - d0), 32'd2);

        // Third strobe in the same run is dropped and flagged.
        d0 = done_cnt;
        pulse();
        run_full(20, 60);
        tick();
        check("ov_set", 32'(overrun), 32'd1);
        run_full(-1, -1);
        repeat (5) begin
            tick();
            check("ov_idle", 32'(busy), 32'd0);
        end
        check("ov_dones", 32'(done_cnt - d0), 32'd2);

        // Strobe coincident with STORE is queued.
        pulse();
        run_full(-1, -1);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        run_full(-1, -1);
        tick();
        check("sim_idle", 32'(busy), 32'd0);
        check("ov_sticky", 32'(overrun), 32'd1);

        // Reset during ISSUE at j=40 abandons the run.
        pulse();
        repeat (41) tick();
        check("mid_coef", 32'(coef_addr), 32'd40);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("mr_ctl", {25'd0, in_wr, acc_clr, mac_en, out_wr, done, busy, overrun}, 32'd0);
        check("mr_adr", {in_addr, coef_addr, out_addr}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (110) tick();
        check("mr_nodone", 32'(done_cnt - d0), 32'd0);
        exp_wp = 0;
        exp_kk = 0;
        pulse();
        run_full(-1, -1);
        tick();

        // Small build: RD_LAT=4 offset/latency and both pointer wraps.
        for (int n = 0; n < 10; n++) begin
            sample_stb2 = 1'b1;
            tick();
            sample_stb2 = 1'b0;
            check("s2_in_wr", 32'(in_wr2), 32'd1);
            check("s2_in_adr", 32'(in_addr2), 32'(n % FO2));
            d0 = mac2_cnt;
            lat = 1;
            while (!done2 && lat < 40) begin
                tick();
                lat++;
                if (!done2)
                    check("s2_mac", 32'(mac_en2), 32'((lat >= 2 + RL2) && (lat <= 1 + FO2 + RL2)));
            end
            check("s2_lat", 32'(lat), 32'(2 + FO2 + RL2));
            check("s2_oaddr", 32'(out_addr2), 32'(n % 8));
            check("s2_maccnt", 32'(mac2_cnt - d0), 32'(FO2));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
